bmf_part_err_monitor: RTL and testbench

- Pipelined error monitor that sits directly downstream of a 10-in/10-out approximated multiplier partition (compressor plus decompressor pair).
- Each transfer carries the exact partition output and the approximated partition output for one input vector. These arrive over a valid/ready stream.
- Accumulates quality-of-result metrics over a run of N_SAMPLES vectors: error count, Hamming-distance sum, absolute-error sum and maximum absolute error. Results feed the factorisation-degree (k) selection loop.

---
 rtl/bmf_qor_pkg.sv | 32 +++
 rtl/bmf_err_stage.sv | 69 ++++++
 rtl/bmf_part_err_monitor.sv | 159 +++++++++++++++
 tb/tb_bmf_part_err_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bmf_qor_pkg.sv
// Shared types and helpers for the BMF partition quality-of-result monitor.
package bmf_qor_pkg;

  localparam int W_OUT_DEF = 10;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Result bit 64 flags saturation; the sum itself is clamped to 2^w-1.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sum > {1'b0, lim}) sat_add = {1'b1, lim};
    else sat_add = {1'b0, sum[63:0]};
  endfunction

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/bmf_err_stage.sv
// Two-stage error datapath: S1 captures XOR and ordered operands, S2 produces
// Hamming distance, absolute error and an error flag with a matching valid.
module bmf_err_stage
  import bmf_qor_pkg::*;
#(
  parameter int W_OUT = W_OUT_DEF,
  parameter int HD_W  = $clog2(W_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W_OUT-1:0] exact_out,
  input  logic [W_OUT-1:0] approx_out,
  output logic             s1_valid,
  output logic             out_valid,
  output logic [HD_W-1:0]  hd,
  output logic [W_OUT-1:0] abs_err,
  output logic             err
);

  logic             s1_valid_reg, s2_valid_reg, err_reg;
  logic [W_OUT-1:0] diff_reg, big_reg, small_reg, abs_reg;
  logic [HD_W-1:0]  hd_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      diff_reg     <= '0;
      big_reg      <= '0;
      small_reg    <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        diff_reg <= exact_out ^ approx_out;
        // Ordering the operands here keeps S2 a plain unsigned subtract.
        if (exact_out >= approx_out) begin
          big_reg   <= exact_out;
          small_reg <= approx_out;
        end else begin
          big_reg   <= approx_out;
          small_reg <= exact_out;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      hd_reg       <= '0;
      abs_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        hd_reg  <= HD_W'(popcount(64'(diff_reg)));
        abs_reg <= big_reg - small_reg;
        err_reg <= |diff_reg;
      end
    end
  end

  assign s1_valid  = s1_valid_reg;
  assign out_valid = s2_valid_reg;
  assign hd        = hd_reg;
  assign abs_err   = abs_reg;
  assign err       = err_reg;

endmodule

// File: rtl/bmf_part_err_monitor.sv
// Run-based QoR monitor for an approximated multiplier partition.
// Define BMF_ERR_HIST_EN to add the Hamming-distance histogram (hist_sel/hist_cnt).
module bmf_part_err_monitor
  import bmf_qor_pkg::*;
#(
  parameter int W_OUT     = W_OUT_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int N_SAMPLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_OUT-1:0] exact_out,
  input  logic [W_OUT-1:0] approx_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] hd_sum,
  output logic [CNT_W-1:0] aed_sum,
  output logic [W_OUT-1:0] max_aed,
  output logic             ovf
`ifdef BMF_ERR_HIST_EN
  ,
  input  logic [$clog2(W_OUT+1)-1:0] hist_sel,
  output logic [CNT_W-1:0]           hist_cnt
`endif
);

  localparam int HD_W = $clog2(W_OUT + 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES - 1);

  state_t           state_reg;
  logic             in_ready_reg, busy_reg, done_reg, ovf_reg;
  logic [CNT_W-1:0] sample_cnt_reg, err_cnt_reg, hd_sum_reg, aed_sum_reg;
  logic [W_OUT-1:0] max_aed_reg;

  logic             accept, run_start;
  logic             s1_valid, s2_valid, s2_err;
  logic [HD_W-1:0]  s2_hd;
  logic [W_OUT-1:0] s2_abs;
  logic [64:0]      hd_add, aed_add;
  logic             unused_sum_bits;

  assign accept    = in_valid & in_ready_reg;
  assign run_start = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));
  assign hd_add    = sat_add(64'(hd_sum_reg), 64'(s2_hd), CNT_W);
  assign aed_add   = sat_add(64'(aed_sum_reg), 64'(s2_abs), CNT_W);
  assign unused_sum_bits = ^{hd_add[63:CNT_W], aed_add[63:CNT_W]};

  bmf_err_stage #(
    .W_OUT(W_OUT),
    .HD_W (HD_W)
  ) u_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .exact_out (exact_out),
    .approx_out(approx_out),
    .s1_valid  (s1_valid),
    .out_valid (s2_valid),
    .hd        (s2_hd),
    .abs_err   (s2_abs),
    .err       (s2_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      in_ready_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      sample_cnt_reg <= '0;
      err_cnt_reg    <= '0;
      hd_sum_reg     <= '0;
      aed_sum_reg    <= '0;
      max_aed_reg    <= '0;
      ovf_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (run_start) begin
            state_reg      <= ST_RUN;
            in_ready_reg   <= 1'b1;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            sample_cnt_reg <= '0;
            err_cnt_reg    <= '0;
            hd_sum_reg     <= '0;
            aed_sum_reg    <= '0;
            max_aed_reg    <= '0;
            ovf_reg        <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
            if (sample_cnt_reg == N_LAST) begin
              state_reg    <= ST_DRAIN;
              in_ready_reg <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!s1_valid && !s2_valid) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // The pipeline is always empty when a run starts, so this never races the clear.
      if (s2_valid) begin
        err_cnt_reg <= err_cnt_reg + CNT_W'(s2_err);
        hd_sum_reg  <= hd_add[CNT_W-1:0];
        aed_sum_reg <= aed_add[CNT_W-1:0];
        if (s2_abs > max_aed_reg) max_aed_reg <= s2_abs;
        ovf_reg <= ovf_reg | hd_add[64] | aed_add[64];
      end
    end
  end

  assign in_ready   = in_ready_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign sample_cnt = sample_cnt_reg;
  assign err_cnt    = err_cnt_reg;
  assign hd_sum     = hd_sum_reg;
  assign aed_sum    = aed_sum_reg;
  assign max_aed    = max_aed_reg;
  assign ovf        = ovf_reg;

`ifdef BMF_ERR_HIST_EN
  logic [CNT_W-1:0] hist_bins [W_OUT+1];

  generate
    for (genvar gi = 0; gi <= W_OUT; gi++) begin : g_bin
      logic [CNT_W-1:0] bin_reg;
      always_ff @(posedge clk) begin
        if (rst || run_start) bin_reg <= '0;
        else if (s2_valid && (s2_hd == HD_W'(gi)) && (bin_reg != '1))
          bin_reg <= bin_reg + 1'b1;
      end
      assign hist_bins[gi] = bin_reg;
    end
  endgenerate

  always_comb begin
    hist_cnt = '0;
    for (int i = 0; i <= W_OUT; i++)
      if (hist_sel == HD_W'(i)) hist_cnt = hist_bins[i];
  end
`endif

endmodule

// File: tb/tb_bmf_part_err_monitor.sv
// Directed bench for bmf_part_err_monitor: a 32-bit N=4 instance for the main
// flows and a 10-bit N=2 instance for accumulator saturation.
module tb_bmf_part_err_monitor;

  localparam int W    = 10;
  localparam int HS_W = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_start, a_valid, a_ready, a_busy, a_done, a_ovf;
  logic [W-1:0] a_exact, a_approx, a_max;
  logic [31:0] a_scnt, a_err, a_hd, a_aed;
  logic b_start, b_valid, b_ready, b_busy, b_done, b_ovf;
  logic [W-1:0] b_exact, b_approx, b_max;
  logic [9:0] b_scnt, b_err, b_hd, b_aed;
`ifdef BMF_ERR_HIST_EN
  logic [HS_W-1:0] a_hsel, b_hsel;
  logic [31:0] a_hcnt;
  logic [9:0]  b_hcnt;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  logic [W-1:0] pat_exact  [4] = '{10'h3FF, 10'h005, 10'h123, 10'h000};
  logic [W-1:0] pat_approx [4] = '{10'h000, 10'h006, 10'h123, 10'h001};

  bmf_part_err_monitor #(.W_OUT(W), .CNT_W(32), .N_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
    .exact_out(a_exact), .approx_out(a_approx), .busy(a_busy), .done(a_done),
    .sample_cnt(a_scnt), .err_cnt(a_err), .hd_sum(a_hd), .aed_sum(a_aed),
    .max_aed(a_max), .ovf(a_ovf)
`ifdef BMF_ERR_HIST_EN
    , .hist_sel(a_hsel), .hist_cnt(a_hcnt)
`endif
  );

  bmf_part_err_monitor #(.W_OUT(W), .CNT_W(10), .N_SAMPLES(2)) dut_sat (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
    .exact_out(b_exact), .approx_out(b_approx), .busy(b_busy), .done(b_done),
    .sample_cnt(b_scnt), .err_cnt(b_err), .hd_sum(b_hd), .aed_sum(b_aed),
    .max_aed(b_max), .ovf(b_ovf)
`ifdef BMF_ERR_HIST_EN
    , .hist_sel(b_hsel), .hist_cnt(b_hcnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start (with in_valid also high, which must be ignored) and check the cleared run.
  task automatic start_run();
    a_start = 1'b1;
    a_valid = 1'b1;
    a_exact = pat_exact[0];
    a_approx = pat_approx[0];
    step();
    a_start = 1'b0;
    chk("start_scnt", a_scnt, 0);
    chk("start_err", a_err, 0);
    chk("start_hd", a_hd, 0);
    chk("start_aed", a_aed, 0);
    chk("start_max", a_max, 0);
    chk("start_ovf", a_ovf, 0);
    chk("start_done", a_done, 0);
    chk("start_busy", a_busy, 1);
    chk("start_ready", a_ready, 1);
`ifdef BMF_ERR_HIST_EN
    chk("start_hist10", a_hcnt, 0);
`endif
  endtask

  // Offer the pattern pairs; returns at the negedge after the n-th transfer edge.
  task automatic feed(input int n, input bit gaps, input int start_at);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 40) begin
      if (start_at >= 0 && cyc == start_at + 1) chk("start_in_run", a_scnt, 32'(idx));
      a_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      a_start = (cyc == start_at);
      a_exact  = a_valid ? pat_exact[idx]  : 10'h2AA;
      a_approx = a_valid ? pat_approx[idx] : 10'h155;
      if (a_valid && a_ready) begin
        $display("xfer %0d exact=%h approx=%h", idx, a_exact, a_approx);
        idx++;
      end
      step();
      cyc++;
    end
    a_start = 1'b0;
    chk("feed_count", 32'(idx), 32'(n));
  endtask

  // Drain with in_valid held high (must be ignored) and check the final results.
  task automatic drain_and_check(input string tag);
    int k = 0;
    bit ready_seen = 0;
    logic [31:0] aed_snap = '0;
    a_valid = 1'b1;
    a_exact = 10'h3FF;
    a_approx = 10'h000;
    while (!a_done && k < 20) begin
      if (a_ready) ready_seen = 1;
      step();
      k++;
      if (k == 2) aed_snap = a_aed;
    end
    chk({tag, "_done_lat"}, 32'(k), 3);
    chk({tag, "_ready_after_last"}, 1'(ready_seen), 0);
    chk({tag, "_aed_at_2"}, aed_snap, 1025);
    chk({tag, "_scnt"}, a_scnt, 4);
    chk({tag, "_err"}, a_err, 3);
    chk({tag, "_hd"}, a_hd, 13);
    chk({tag, "_aed"}, a_aed, 1025);
    chk({tag, "_max"}, a_max, 10'h3FF);
    chk({tag, "_ovf"}, a_ovf, 0);
    chk({tag, "_busy"}, a_busy, 0);
    step();
    chk({tag, "_frozen_done"}, a_done, 1);
    chk({tag, "_frozen_scnt"}, a_scnt, 4);
    a_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nb;
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_exact = '0; a_approx = '0;
    b_start = 0; b_valid = 0; b_exact = '0; b_approx = '0;
`ifdef BMF_ERR_HIST_EN
    a_hsel = HS_W'(10);
    b_hsel = HS_W'(10);
`endif
    step();
    step();
    chk("rst_ready", a_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_scnt", a_scnt, 0);
    chk("rst_aed", a_aed, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_b_ready", b_ready, 0);
    rst = 1'b0;
    step();

    // Run 1: in_valid held high.
    start_run();
    feed(4, 1'b0, -1);
    drain_and_check("run1");

`ifdef BMF_ERR_HIST_EN
    for (int s = 0; s < 16; s++) begin
      a_hsel = HS_W'(s);
      #1;
      chk($sformatf("hist%0d", s), a_hcnt, (s == 0 || s == 1 || s == 2 || s == 10) ? 1 : 0);
    end
    a_hsel = HS_W'(10);
    @(negedge clk);
`endif

    // Run 2: restart from DONE, in_valid toggling, stray start mid-run.
    start_run();
    feed(4, 1'b1, 3);
    drain_and_check("run2");

    // Reset mid-run after two transfers.
    start_run();
    feed(2, 1'b0, -1);
    step();
    rst = 1'b1;
    a_valid = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ready", a_ready, 0);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_done", a_done, 0);
    chk("mrst_scnt", a_scnt, 0);
    chk("mrst_err", a_err, 0);
    chk("mrst_hd", a_hd, 0);
    chk("mrst_aed", a_aed, 0);
    chk("mrst_max", a_max, 0);
    chk("mrst_ovf", a_ovf, 0);
    step();
    chk("mrst_ready_next", a_ready, 0);
    chk("mrst_idle_scnt", a_scnt, 0);
    step();
    chk("mrst_flushed_hd", a_hd, 0);
    a_valid = 1'b0;

    // Saturation with 10-bit accumulators.
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_valid = 1'b1;
    b_exact = 10'h3FF;
    b_approx = 10'h000;
    k = 0;
    nb = 0;
    while (nb < 2 && k < 20) begin
      if (b_valid && b_ready) begin
        $display("xfer sat %0d exact=%h approx=%h", nb, b_exact, b_approx);
        nb++;
      end
      step();
      k++;
    end
    b_valid = 1'b0;
    k = 0;
    while (!b_done && k < 20) begin
      step();
      k++;
    end
    chk("sat_done", b_done, 1);
    chk("sat_scnt", b_scnt, 2);
    chk("sat_aed", b_aed, 10'h3FF);
    chk("sat_ovf", b_ovf, 1);
    chk("sat_hd", b_hd, 20);
    chk("sat_err", b_err, 2);
    chk("sat_max", b_max, 10'h3FF);
`ifdef BMF_ERR_HIST_EN
    chk("sat_hist10", b_hcnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
